mem_access_unit: RTL and testbench

- Responder for the decoder's MemWrite/MemCtrl output.
- Accepts one load/store request per transaction from the execute/memory stage and drives a word-organised data memory over a req/ack handshake.
- Generates byte enables and aligns write data; sign- or zero-extends load data.
- Splits misaligned halfword and word accesses into two aligned beats.

---
 rtl/mem_access_unit_pkg.sv | 44 ++++
 rtl/mem_access_unit_lane_align.sv | 43 ++++
 rtl/mem_access_unit.sv | 185 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings, FSM state type and lane helpers for the load/store unit.
// Memory-size codes match the decoder's MEM_* field.
package mem_access_unit_pkg;

    localparam logic [2:0] MEM_B  = 3'd0;
    localparam logic [2:0] MEM_H  = 3'd1;
    localparam logic [2:0] MEM_W  = 3'd2;
    localparam logic [2:0] MEM_BU = 3'd4;
    localparam logic [2:0] MEM_HU = 3'd5;

    localparam logic [3:0] LANE_B = 4'b0001;
    localparam logic [3:0] LANE_H = 4'b0011;
    localparam logic [3:0] LANE_W = 4'b1111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } mau_state_e;

    function automatic logic [3:0] lane_mask(input logic [2:0] ctrl);
        case (ctrl)
            MEM_H, MEM_HU: lane_mask = LANE_H;
            MEM_W:         lane_mask = LANE_W;
            default:       lane_mask = LANE_B;
        endcase
    endfunction

    // Unsigned sizes only make sense for loads.
    function automatic logic is_illegal(input logic wr, input logic [2:0] ctrl);
        case (ctrl)
            MEM_B, MEM_H, MEM_W: is_illegal = 1'b0;
            MEM_BU, MEM_HU:      is_illegal = wr;
            default:             is_illegal = 1'b1;
        endcase
    endfunction

    function automatic logic needs_split(input logic [2:0] ctrl, input logic [1:0] off);
        needs_split = (((ctrl == MEM_H) || (ctrl == MEM_HU)) && (off == 2'd3)) ||
                      ((ctrl == MEM_W) && (off != 2'd0));
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational lane steering: byte enables and write data for both beats,
// plus shift-down and sign/zero extension of the captured load data.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [3:0]  mask,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [63:0] rdata64,
    input  logic [2:0]  memctrl,
    output logic [3:0]  be0,
    output logic [3:0]  be1,
    output logic [31:0] wd0,
    output logic [31:0] wd1,
    output logic [31:0] ld_rdata
);

    logic [7:0]  be_sh;
    logic [63:0] wd_sh;
    logic [63:0] rd_sh;

    function automatic logic [31:0] extend(input logic [2:0] ctrl, input logic [31:0] v);
        case (ctrl)
            MEM_B:   extend = {{24{v[7]}}, v[7:0]};
            MEM_BU:  extend = {24'd0, v[7:0]};
            MEM_H:   extend = {{16{v[15]}}, v[15:0]};
            MEM_HU:  extend = {16'd0, v[15:0]};
            default: extend = v;
        endcase
    endfunction

    always_comb begin
        be_sh    = {4'b0000, mask} << off;
        wd_sh    = {32'd0, wdata} << {off, 3'b000};
        rd_sh    = rdata64 >> {off, 3'b000};
        be0      = be_sh[3:0];
        be1      = be_sh[7:4];
        wd0      = wd_sh[31:0];
        wd1      = wd_sh[63:32];
        ld_rdata = extend(memctrl, rd_sh[31:0]);
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: accepts one request, issues one or two aligned word beats
// over req/ack, and returns a single-cycle response with extended load data.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_memctrl,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] TO_N = 32'(TIMEOUT_CYCLES);

    mau_state_e  state, state_d;
    logic        wr_q;
    logic [31:0] addr_q, wdata_q, lo_q;
    logic [2:0]  ctrl_q;
    logic [31:0] cnt_q, cnt_d;

    logic        req_ready_d, rsp_valid_d, rsp_err_d, mem_req_d, mem_we_d;
    logic [31:0] rsp_rdata_d, mem_addr_d, mem_wdata_d;
    logic [3:0]  mem_be_d;

    logic        idle, accept, split_m, beat_ack;
    logic [31:0] addr_m, wdata_m, base_m, lo_in, hi_in;
    logic [2:0]  ctrl_m;
    logic [3:0]  be0, be1;
    logic [31:0] wd0, wd1, ld_rdata;

    // In IDLE the beat-0 outputs are built straight from the request so the
    // first beat can be registered on the accept edge.
    assign idle     = (state == IDLE);
    assign accept   = idle && req_valid && req_ready;
    assign addr_m   = idle ? req_addr    : addr_q;
    assign wdata_m  = idle ? req_wdata   : wdata_q;
    assign ctrl_m   = idle ? req_memctrl : ctrl_q;
    assign split_m  = needs_split(ctrl_m, addr_m[1:0]);
    assign base_m   = {addr_m[31:2], 2'b00};
    assign beat_ack = mem_req && mem_ack;
    assign lo_in    = ((state == BEAT0) && beat_ack) ? mem_rdata : lo_q;
    assign hi_in    = split_m ? mem_rdata : 32'd0;

    mem_lane_align u_align (
        .mask     (lane_mask(ctrl_m)),
        .off      (addr_m[1:0]),
        .wdata    (wdata_m),
        .rdata64  ({hi_in, lo_in}),
        .memctrl  (ctrl_m),
        .be0      (be0),
        .be1      (be1),
        .wd0      (wd0),
        .wd1      (wd1),
        .ld_rdata (ld_rdata)
    );

    always_comb begin
        state_d     = state;
        cnt_d       = cnt_q;
        req_ready_d = req_ready;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = rsp_rdata;
        mem_req_d   = mem_req;
        mem_we_d    = mem_we;
        mem_addr_d  = mem_addr;
        mem_be_d    = mem_be;
        mem_wdata_d = mem_wdata;

        case (state)
            IDLE: begin
                if (accept) begin
                    req_ready_d = 1'b0;
                    if (is_illegal(req_write, req_memctrl)) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'd0;
                    end else begin
                        state_d     = BEAT0;
                        cnt_d       = 32'd0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_write;
                        mem_addr_d  = base_m;
                        mem_be_d    = be0;
                        mem_wdata_d = wd0;
                    end
                end
            end
            BEAT0, BEAT1: begin
                if (mem_req) begin
                    if (mem_ack) begin
                        mem_req_d = 1'b0;
                        mem_we_d  = 1'b0;
                        cnt_d     = 32'd0;
                        if ((state == BEAT0) && split_m) begin
                            state_d = BEAT1;
                        end else begin
                            state_d     = RESP;
                            rsp_valid_d = 1'b1;
                            rsp_rdata_d = wr_q ? 32'd0 : ld_rdata;
                        end
                    end else if ((TO_N != 32'd0) && (cnt_q + 32'd1 == TO_N)) begin
                        // Abandon the access, including any pending second beat.
                        mem_req_d   = 1'b0;
                        mem_we_d    = 1'b0;
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'd0;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end else if (state == BEAT1) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = wr_q;
                    mem_addr_d  = base_m + 32'd4;
                    mem_be_d    = be1;
                    mem_wdata_d = wd1;
                    cnt_d       = 32'd0;
                end
            end
            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt_q     <= 32'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_be    <= 4'd0;
            mem_wdata <= 32'd0;
        end else begin
            state     <= state_d;
            cnt_q     <= cnt_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_err   <= rsp_err_d;
            rsp_rdata <= rsp_rdata_d;
            mem_req   <= mem_req_d;
            mem_we    <= mem_we_d;
            mem_addr  <= mem_addr_d;
            mem_be    <= mem_be_d;
            mem_wdata <= mem_wdata_d;
        end
    end

    // Request fields and the low load word need no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            ctrl_q  <= req_memctrl;
        end
        lo_q <= lo_in;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: a small memory responder pops expected
// beats and responses pushed by each scenario task.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [2:0]  req_memctrl = 3'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } beat_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    beat_t exp_beat_q[$];
    rsp_t  exp_rsp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int rsp_k;
    int req_cycles;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_memctrl (req_memctrl),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata)
    );

    // Drives one request, then acts as memory (acking each beat after
    // `delay` waiting cycles) until the response pulse or a cycle budget.
    task automatic run_txn(input string name, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic [2:0] c, input int delay);
        int    k = 0;
        int    waitc = 0;
        logic  prev_req = 1'b0;
        logic  done = 1'b0;
        beat_t cur;
        rsp_t  er;
        cur = '{we: 1'b0, addr: 32'd0, be: 4'd0, wdata: 32'd0, rdata: 32'd0};
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_memctrl = c;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rsp_k = -1;
        req_cycles = 0;
        while (!done && k < 60) begin
            @(negedge clk);
            k++;
            if (mem_req) begin
                req_cycles++;
                if (!prev_req) begin
                    n_checks++;
                    if (exp_beat_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL %s unexpected beat: got addr=%h be=%b, required none", name, mem_addr, mem_be);
                    end else begin
                        cur = exp_beat_q.pop_front();
                        if (mem_we !== cur.we || mem_addr !== cur.addr || mem_be !== cur.be ||
                            (cur.we && mem_wdata !== cur.wdata)) begin
                            n_fail++;
                            $display("FAIL %s beat: got we=%b addr=%h be=%b wdata=%h, required we=%b addr=%h be=%b wdata=%h",
                                     name, mem_we, mem_addr, mem_be, mem_wdata, cur.we, cur.addr, cur.be, cur.wdata);
                        end
                    end
                    waitc = 0;
                end else begin
                    n_checks++;
                    if (mem_addr !== cur.addr || mem_be !== cur.be) begin
                        n_fail++;
                        $display("FAIL %s beat_stable: got addr=%h be=%b, required addr=%h be=%b",
                                 name, mem_addr, mem_be, cur.addr, cur.be);
                    end
                end
                if (waitc >= delay) begin
                    mem_ack = 1'b1;
                    mem_rdata = cur.rdata;
                end else begin
                    mem_ack = 1'b0;
                    waitc++;
                end
            end else begin
                mem_ack = 1'b0;
            end
            prev_req = mem_req;
            if (rsp_valid) begin
                rsp_k = k;
                done = 1'b1;
                n_checks++;
                if (exp_rsp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s unexpected rsp: got rdata=%h err=%b", name, rsp_rdata, rsp_err);
                end else begin
                    er = exp_rsp_q.pop_front();
                    if (rsp_rdata !== er.rdata || rsp_err !== er.err) begin
                        n_fail++;
                        $display("FAIL %s rsp: got rdata=%h err=%b, required rdata=%h err=%b",
                                 name, rsp_rdata, rsp_err, er.rdata, er.err);
                    end
                end
            end
        end
        mem_ack = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s no_rsp: got no rsp_valid within 60 cycles, required one", name);
        end
        @(negedge clk);
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_rsp: got rsp_valid=%b req_ready=%b mem_req=%b, required 0 1 0",
                     name, rsp_valid, req_ready, mem_req);
        end
        n_checks++;
        if (exp_beat_q.size() != 0 || exp_rsp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s leftovers: got %0d beats %0d rsps pending, required 0 0",
                     name, exp_beat_q.size(), exp_rsp_q.size());
            exp_beat_q.delete();
            exp_rsp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_err !== 1'b0 || mem_req !== 1'b0 ||
            mem_we !== 1'b0 || rsp_rdata !== 32'd0 || mem_addr !== 32'd0 || mem_be !== 4'd0 ||
            mem_wdata !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: got ready=%b vld=%b err=%b req=%b we=%b rdata=%h addr=%h be=%b wdata=%h, required 1 0 0 0 0 0 0 0 0",
                     req_ready, rsp_valid, rsp_err, mem_req, mem_we, rsp_rdata, mem_addr, mem_be, mem_wdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_byte();
        exp_beat_q.push_back('{we: 1'b0, addr: 32'h1000, be: 4'b1000, wdata: 32'd0, rdata: 32'h80FF_FF11});
        exp_rsp_q.push_back('{rdata: 32'hFFFF_FF80, err: 1'b0});
        run_txn("load_b", 1'b0, 32'h1003, 32'd0, 3'd0, 0);
        n_checks++;
        if (rsp_k != 2) begin
            n_fail++;
            $display("FAIL load_b latency: got rsp %0d cycles after accept, required 2", rsp_k);
        end
    endtask

    task automatic test_store_half();
        exp_beat_q.push_back('{we: 1'b1, addr: 32'h2000, be: 4'b1100, wdata: 32'hABCD_0000, rdata: 32'd0});
        exp_rsp_q.push_back('{rdata: 32'd0, err: 1'b0});
        run_txn("store_h", 1'b1, 32'h2002, 32'h1234_ABCD, 3'd1, 1);
    endtask

    task automatic test_split_load();
        exp_beat_q.push_back('{we: 1'b0, addr: 32'h3000, be: 4'b1110, wdata: 32'd0, rdata: 32'h4433_2211});
        exp_beat_q.push_back('{we: 1'b0, addr: 32'h3004, be: 4'b0001, wdata: 32'd0, rdata: 32'h8877_6655});
        exp_rsp_q.push_back('{rdata: 32'h5544_3322, err: 1'b0});
        run_txn("load_w_split", 1'b0, 32'h3001, 32'd0, 3'd2, 0);
    endtask

    task automatic test_wrap_store();
        exp_beat_q.push_back('{we: 1'b1, addr: 32'hFFFF_FFFC, be: 4'b1100, wdata: 32'hBBAA_0000, rdata: 32'd0});
        exp_beat_q.push_back('{we: 1'b1, addr: 32'h0000_0000, be: 4'b0011, wdata: 32'h0000_DDCC, rdata: 32'd0});
        exp_rsp_q.push_back('{rdata: 32'd0, err: 1'b0});
        run_txn("store_w_wrap", 1'b1, 32'hFFFF_FFFE, 32'hDDCC_BBAA, 3'd2, 0);
    endtask

    task automatic test_illegal();
        exp_rsp_q.push_back('{rdata: 32'd0, err: 1'b1});
        run_txn("store_hu", 1'b1, 32'h40, 32'hFFFF_FFFF, 3'd5, 0);
        exp_rsp_q.push_back('{rdata: 32'd0, err: 1'b1});
        run_txn("load_code3", 1'b0, 32'h44, 32'd0, 3'd3, 0);
        exp_rsp_q.push_back('{rdata: 32'd0, err: 1'b1});
        run_txn("load_code7", 1'b0, 32'h48, 32'd0, 3'd7, 0);
    endtask

    task automatic test_extend();
        logic [31:0] t_addr[5]  = '{32'h5, 32'h5, 32'h2, 32'h2, 32'h8};
        logic [2:0]  t_ctrl[5]  = '{3'd1, 3'd5, 3'd4, 3'd0, 3'd2};
        logic [3:0]  t_be[5]    = '{4'b0110, 4'b0110, 4'b0100, 4'b0100, 4'b1111};
        logic [31:0] t_rd[5]    = '{32'h00F0_F000, 32'h00F0_F000, 32'h00AB_0000, 32'h00AB_0000, 32'hCAFE_BABE};
        logic [31:0] t_exp[5]   = '{32'hFFFF_F0F0, 32'h0000_F0F0, 32'h0000_00AB, 32'hFFFF_FFAB, 32'hCAFE_BABE};
        for (int i = 0; i < 5; i++) begin
            exp_beat_q.push_back('{we: 1'b0, addr: {t_addr[i][31:2], 2'b00}, be: t_be[i], wdata: 32'd0, rdata: t_rd[i]});
            exp_rsp_q.push_back('{rdata: t_exp[i], err: 1'b0});
            run_txn($sformatf("extend%0d", i), 1'b0, t_addr[i], 32'd0, t_ctrl[i], i % 3);
        end
    endtask

    task automatic test_back_to_back();
        exp_beat_q.push_back('{we: 1'b0, addr: 32'h4, be: 4'b1000, wdata: 32'd0, rdata: 32'hAA00_0000});
        exp_beat_q.push_back('{we: 1'b0, addr: 32'h8, be: 4'b0001, wdata: 32'd0, rdata: 32'h0000_00BB});
        exp_rsp_q.push_back('{rdata: 32'hFFFF_BBAA, err: 1'b0});
        run_txn("b2b_load_h_split", 1'b0, 32'h7, 32'd0, 3'd1, 2);
        exp_beat_q.push_back('{we: 1'b1, addr: 32'h0, be: 4'b0010, wdata: 32'h0000_5500, rdata: 32'd0});
        exp_rsp_q.push_back('{rdata: 32'd0, err: 1'b0});
        run_txn("b2b_store_b", 1'b1, 32'h1, 32'h1234_5655 & 32'h0000_0055, 3'd0, 1);
    endtask

    task automatic test_timeout();
        exp_beat_q.push_back('{we: 1'b0, addr: 32'h10, be: 4'b0011, wdata: 32'd0, rdata: 32'hFFFF_FFFF});
        exp_rsp_q.push_back('{rdata: 32'd0, err: 1'b1});
        run_txn("timeout_hu", 1'b0, 32'h10, 32'd0, 3'd5, 1000);
        n_checks++;
        if (req_cycles != 4) begin
            n_fail++;
            $display("FAIL timeout_req_cycles: got mem_req high %0d cycles, required 4", req_cycles);
        end
    endtask

    task automatic test_reset_mid_beat();
        logic saw_rsp = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h100; req_wdata = 32'h1; req_memctrl = 3'd2;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid setup: got mem_req=%b, required 1", mem_req);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || req_ready !== 1'b1 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid async: got mem_req=%b req_ready=%b mem_we=%b, required 0 1 0",
                     mem_req, req_ready, mem_we);
        end
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) saw_rsp = 1'b1;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid || mem_req) saw_rsp = 1'b1;
        end
        n_checks++;
        if (saw_rsp !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid quiet: got activity=%b req_ready=%b, required 0 1", saw_rsp, req_ready);
        end
        exp_beat_q.push_back('{we: 1'b0, addr: 32'h200, be: 4'b1111, wdata: 32'd0, rdata: 32'h0BAD_F00D});
        exp_rsp_q.push_back('{rdata: 32'h0BAD_F00D, err: 1'b0});
        run_txn("after_reset_load_w", 1'b0, 32'h200, 32'd0, 3'd2, 0);
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_store_half();
        test_split_load();
        test_wrap_store();
        test_illegal();
        test_extend();
        test_back_to_back();
        test_timeout();
        test_reset_mid_beat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
